taillight_sequencer: RTL and testbench
======================================

Name: taillight_sequencer

Overview:
- Controller that schedules the 10-lamp tail-light bar (LEDR) and the HEX0 mode glyph from level requests: hazard, left turn, right turn and brake.
- A built-in prescaler divides ADC_CLK_10 into step ticks. A priority arbiter picks the active mode, and a state machine steps the lamp sequence one state per tick.
- Sits between the board-level key/switch conditioning and the LEDR/HEX0 pins.

Parameters:
- DIV, 16: ADC_CLK_10 cycles per sequence step. Must be at least 2.

Ports:
- ADC_CLK_10  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear pulse.
- hazard_req  in  1  level request, hazard flash.
- left_req  in  1  level request, left sweep.
- right_req  in  1  level request, right sweep.
- brake_req  in  1  level request, brake overlay.
- led  out  10  lamp bar, bit 9 leftmost.
- hex0  out  8  active-low seven-segment glyph.
- mode  out  2  current mode: 00 idle, 01 left, 10 right, 11 hazard.
- busy  out  1  high when the state is not IDLE.
- tick  out  1  one-cycle step strobe.

Behaviour:
- Reset, asynchronous via rst_n low:
  - state = IDLE, prescaler count = 0, brake_q = 0.
  - Outputs: led = 0, hex0 = 8'hFF, mode = 00, busy = 0, tick = 0.
- Prescaler:
  - cnt counts 0 to DIV-1 and wraps to 0.
  - tick = (cnt == DIV-1), combinational from cnt.
  - First tick occurs on the DIV-th rising edge after reset release.
- clr:
  - On the next edge, forces state = IDLE and cnt = 0.
  - Has priority over tick and over all requests.
- Arbiter, sampled only at tick edges:
  - Requested mode priority: hazard_req, then (left_req & right_req), which counts as hazard, then left, then right, then idle.
- States: IDLE, HAZ_ON, HAZ_OFF, L1, L2, L3, L0, R1, R2, R3, R0.
- Transitions, on an edge with tick = 1:
  - Requested idle: next state IDLE from any state.
  - Requested mode differs from current mode: jump to that mode's first state (HAZ_ON, L1 or R1).
  - Same mode: advance within the mode.
    - Hazard: HAZ_ON -> HAZ_OFF -> HAZ_ON.
    - Left: L1 -> L2 -> L3 -> L0 -> L1.
    - Right: R1 -> R2 -> R3 -> R0 -> R1.
  - With no tick, the state holds. Requests that appear and vanish between ticks are ignored.
- Lamp patterns, decoded from the state flops (no extra latency):
  - IDLE, HAZ_OFF, L0, R0: 10'b0.
  - HAZ_ON: 10'b11_1000_0111.
  - L1: 10'b00_1000_0000. L2: 10'b01_1000_0000. L3: 10'b11_1000_0000.
  - R1: 10'b00_0000_0100. R2: 10'b00_0000_0110. R3: 10'b00_0000_0111.
- Brake:
  - brake_q is registered from brake_req every cycle, independent of tick.
  - led = pattern | (brake_q ? 10'b00_0111_1000 : 0), so brake latency is 1 cycle.
  - clr does not clear brake_q; only rst_n does.
- Glyphs:
  - hex0 = 8'h89 for hazard states, 8'hC7 for left states, 8'hAF for right states, 8'hFF for IDLE.
  - mode is encoded from state.
- Boundaries:
  - A request change exactly on a tick edge takes effect on that edge.
  - Reset asserted mid-sequence clears everything immediately.
  - After a mode change, the new sequence restarts at step 1 and never resumes a partial sweep.

Decomposition:
- Package taillight_pkg holds:
  - state enum;
  - MODE_* codes;
  - the eight lamp-pattern constants and BRAKE_MASK;
  - glyph constants GLYPH_HAZ, GLYPH_L, GLYPH_R, GLYPH_OFF.
- One sub-module, step_prescaler:
  - Parameter DIV; ports ADC_CLK_10, rst_n, clr, tick.
  - Counter width is $clog2(DIV).

Test Plan:
- DIV=4, reset release, left_req held:
  - Edge 4: led = 0010000000.
  - Edge 8: 0110000000. Edge 12: 1110000000. Edge 16: 0. Edge 20: 0010000000.
  - hex0 = C7 from edge 4 onward.
- DIV=4, hazard_req held: led alternates 1110000111 and 0 every 4 edges; hex0 = 89; mode = 11.
- Right sweep at R2, then left_req raised with right_req still high: next tick gives HAZ_ON (led = 1110000111).
  - Drop both requests: next tick gives led = 0, busy = 0.
- brake_req pulse for 1 cycle while idle, with no tick in between: led = 0001111000 for exactly 1 cycle, starting 1 edge later; state unchanged.
- Mid-sweep at L3, pulse clr: next edge gives led = 0 and hex0 = FF.
  - With left_req still high, L1 appears DIV edges after clr.
- rst_n driven low asynchronously between edges during HAZ_ON: led = 0, hex0 = FF, tick = 0 immediately.
  - After release, first tick occurs on edge DIV.

Source files
------------

// File: rtl/taillight_pkg.sv
// Shared types and constants for the tail-light bar sequencer: states, mode
// codes, lamp patterns and seven-segment glyphs.
package taillight_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_HAZ_ON, S_HAZ_OFF,
    S_L1, S_L2, S_L3, S_L0,
    S_R1, S_R2, S_R3, S_R0
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_HAZ   = 2'b11;

  // Bit 9 is the leftmost lamp.
  localparam logic [9:0] PAT_OFF = 10'b00_0000_0000;
  localparam logic [9:0] PAT_HAZ = 10'b11_1000_0111;
  localparam logic [9:0] PAT_L1  = 10'b00_1000_0000;
  localparam logic [9:0] PAT_L2  = 10'b01_1000_0000;
  localparam logic [9:0] PAT_L3  = 10'b11_1000_0000;
  localparam logic [9:0] PAT_R1  = 10'b00_0000_0100;
  localparam logic [9:0] PAT_R2  = 10'b00_0000_0110;
  localparam logic [9:0] PAT_R3  = 10'b00_0000_0111;
  localparam logic [9:0] BRAKE_MASK = 10'b00_0111_1000;

  localparam logic [7:0] GLYPH_HAZ = 8'h89;
  localparam logic [7:0] GLYPH_L   = 8'hC7;
  localparam logic [7:0] GLYPH_R   = 8'hAF;
  localparam logic [7:0] GLYPH_OFF = 8'hFF;

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      S_HAZ_ON, S_HAZ_OFF:     mode_of = MODE_HAZ;
      S_L1, S_L2, S_L3, S_L0:  mode_of = MODE_LEFT;
      S_R1, S_R2, S_R3, S_R0:  mode_of = MODE_RIGHT;
      default:                 mode_of = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the board clock into a one-cycle step strobe every DIV cycles.
module step_prescaler #(
  parameter int DIV = 16
) (
  input  logic ADC_CLK_10,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/taillight_sequencer.sv
// Tail-light bar sequencer: arbitrates hazard/left/right requests at each step
// tick, walks the lamp sequence, and overlays a registered brake mask.
module taillight_sequencer
  import taillight_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       ADC_CLK_10,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       hazard_req,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       brake_req,
  output logic [9:0] led,
  output logic [7:0] hex0,
  output logic [1:0] mode,
  output logic       busy,
  output logic       tick
);
  state_t     state, state_nxt;
  logic       brake_q;
  logic [1:0] req_mode;
  logic [9:0] pattern;

  step_prescaler #(.DIV(DIV)) u_presc (
    .ADC_CLK_10 (ADC_CLK_10),
    .rst_n      (rst_n),
    .clr        (clr),
    .tick       (tick)
  );

  // Both turn signals at once is treated as a hazard request.
  always_comb begin
    req_mode = MODE_IDLE;
    if (hazard_req || (left_req && right_req)) req_mode = MODE_HAZ;
    else if (left_req)                         req_mode = MODE_LEFT;
    else if (right_req)                        req_mode = MODE_RIGHT;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else if (tick) begin
      if (req_mode == MODE_IDLE) begin
        state_nxt = S_IDLE;
      end else if (req_mode != mode) begin
        case (req_mode)
          MODE_HAZ:  state_nxt = S_HAZ_ON;
          MODE_LEFT: state_nxt = S_L1;
          default:   state_nxt = S_R1;
        endcase
      end else begin
        case (state)
          S_HAZ_ON:  state_nxt = S_HAZ_OFF;
          S_HAZ_OFF: state_nxt = S_HAZ_ON;
          S_L1:      state_nxt = S_L2;
          S_L2:      state_nxt = S_L3;
          S_L3:      state_nxt = S_L0;
          S_L0:      state_nxt = S_L1;
          S_R1:      state_nxt = S_R2;
          S_R2:      state_nxt = S_R3;
          S_R3:      state_nxt = S_R0;
          S_R0:      state_nxt = S_R1;
          default:   state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Brake is sampled every cycle and deliberately survives clr.
  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      brake_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      brake_q <= brake_req;
    end
  end

  always_comb begin
    pattern = PAT_OFF;
    hex0    = GLYPH_OFF;
    case (state)
      S_HAZ_ON:  begin pattern = PAT_HAZ; hex0 = GLYPH_HAZ; end
      S_HAZ_OFF: hex0 = GLYPH_HAZ;
      S_L1:      begin pattern = PAT_L1; hex0 = GLYPH_L; end
      S_L2:      begin pattern = PAT_L2; hex0 = GLYPH_L; end
      S_L3:      begin pattern = PAT_L3; hex0 = GLYPH_L; end
      S_L0:      hex0 = GLYPH_L;
      S_R1:      begin pattern = PAT_R1; hex0 = GLYPH_R; end
      S_R2:      begin pattern = PAT_R2; hex0 = GLYPH_R; end
      S_R3:      begin pattern = PAT_R3; hex0 = GLYPH_R; end
      S_R0:      hex0 = GLYPH_R;
      default:   ;
    endcase
  end

  assign led  = pattern | (brake_q ? BRAKE_MASK : 10'b0);
  assign mode = mode_of(state);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed bench for taillight_sequencer with DIV=4; edges are counted from
// reset release and outputs are sampled 1 time unit after each rising edge.
module tb_taillight_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, clr, hazard_req, left_req, right_req, brake_req;
  logic [9:0] led;
  logic [7:0] hex0;
  logic [1:0] mode;
  logic       busy, tick;
  int         checks = 0;
  int         errors = 0;

  taillight_sequencer #(.DIV(4)) dut (
    .ADC_CLK_10 (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .hazard_req (hazard_req),
    .left_req   (left_req),
    .right_req  (right_req),
    .brake_req  (brake_req),
    .led        (led),
    .hex0       (hex0),
    .mode       (mode),
    .busy       (busy),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_run();
    rst_n = 1'b0; clr = 1'b0;
    hazard_req = 1'b0; left_req = 1'b0; right_req = 1'b0; brake_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    begin_run();
    #1;
    checks++; if (led !== 10'b0) begin errors++; $display("FAIL reset_led got=%b exp=%b", led, 10'b0); end
    checks++; if (hex0 !== 8'hFF) begin errors++; $display("FAIL reset_hex got=%h exp=ff", hex0); end
    checks++; if ({mode, busy, tick} !== 4'b0) begin errors++; $display("FAIL reset_mbt got=%b exp=0000", {mode, busy, tick}); end
  endtask

  task automatic test_left();
    begin_run();
    left_req = 1'b1;
    release_reset();
    step(2);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL left_e2_tick got=%b exp=0", tick); end
    step(1);
    checks++; if ({tick, led} !== {1'b1, 10'b0}) begin errors++; $display("FAIL left_e3 got=%b exp=%b", {tick, led}, {1'b1, 10'b0}); end
    step(1);
    checks++; if (led !== 10'b0010000000) begin errors++; $display("FAIL left_e4_led got=%b exp=0010000000", led); end
    checks++; if ({hex0, mode, busy} !== {8'hC7, 2'b01, 1'b1}) begin errors++; $display("FAIL left_e4_glyph got=%h/%b/%b exp=c7/01/1", hex0, mode, busy); end
    step(4);
    checks++; if (led !== 10'b0110000000) begin errors++; $display("FAIL left_e8_led got=%b exp=0110000000", led); end
    step(4);
    checks++; if (led !== 10'b1110000000) begin errors++; $display("FAIL left_e12_led got=%b exp=1110000000", led); end
    step(4);
    checks++; if ({led, hex0} !== {10'b0, 8'hC7}) begin errors++; $display("FAIL left_e16 got=%b/%h exp=0/c7", led, hex0); end
    step(4);
    checks++; if (led !== 10'b0010000000) begin errors++; $display("FAIL left_e20_led got=%b exp=0010000000", led); end
  endtask

  task automatic test_hazard();
    begin_run();
    hazard_req = 1'b1;
    release_reset();
    step(4);
    checks++; if ({led, hex0, mode} !== {10'b1110000111, 8'h89, 2'b11}) begin errors++; $display("FAIL haz_e4 got=%b/%h/%b exp=1110000111/89/11", led, hex0, mode); end
    step(4);
    checks++; if ({led, hex0, mode, busy} !== {10'b0, 8'h89, 2'b11, 1'b1}) begin errors++; $display("FAIL haz_e8 got=%b/%h/%b/%b exp=0/89/11/1", led, hex0, mode, busy); end
    step(4);
    checks++; if (led !== 10'b1110000111) begin errors++; $display("FAIL haz_e12_led got=%b exp=1110000111", led); end
  endtask

  task automatic test_right_to_hazard();
    begin_run();
    right_req = 1'b1;
    release_reset();
    step(4);
    checks++; if ({led, hex0, mode} !== {10'b0000000100, 8'hAF, 2'b10}) begin errors++; $display("FAIL right_e4 got=%b/%h/%b exp=0000000100/af/10", led, hex0, mode); end
    step(4);
    checks++; if (led !== 10'b0000000110) begin errors++; $display("FAIL right_e8_led got=%b exp=0000000110", led); end
    left_req = 1'b1;
    step(3);
    checks++; if (led !== 10'b0000000110) begin errors++; $display("FAIL right_e11_hold got=%b exp=0000000110", led); end
    step(1);
    checks++; if ({led, mode} !== {10'b1110000111, 2'b11}) begin errors++; $display("FAIL both_e12 got=%b/%b exp=1110000111/11", led, mode); end
    left_req = 1'b0; right_req = 1'b0;
    step(4);
    checks++; if ({led, busy, hex0} !== {10'b0, 1'b0, 8'hFF}) begin errors++; $display("FAIL drop_e16 got=%b/%b/%h exp=0/0/ff", led, busy, hex0); end
  endtask

  task automatic test_brake();
    begin_run();
    release_reset();
    step(1);
    brake_req = 1'b1;
    checks++; if (led !== 10'b0) begin errors++; $display("FAIL brake_e1 got=%b exp=0", led); end
    step(1);
    brake_req = 1'b0;
    checks++; if ({led, busy} !== {10'b0001111000, 1'b0}) begin errors++; $display("FAIL brake_e2 got=%b/%b exp=0001111000/0", led, busy); end
    step(1);
    checks++; if ({led, hex0} !== {10'b0, 8'hFF}) begin errors++; $display("FAIL brake_e3 got=%b/%h exp=0/ff", led, hex0); end
  endtask

  task automatic test_clr();
    begin_run();
    left_req = 1'b1;
    release_reset();
    step(12);
    checks++; if (led !== 10'b1110000000) begin errors++; $display("FAIL clr_pre_l3 got=%b exp=1110000000", led); end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++; if ({led, hex0, busy} !== {10'b0, 8'hFF, 1'b0}) begin errors++; $display("FAIL clr_e13 got=%b/%h/%b exp=0/ff/0", led, hex0, busy); end
    step(3);
    checks++; if ({led, hex0} !== {10'b0, 8'hFF}) begin errors++; $display("FAIL clr_e16 got=%b/%h exp=0/ff", led, hex0); end
    step(1);
    checks++; if ({led, hex0} !== {10'b0010000000, 8'hC7}) begin errors++; $display("FAIL clr_e17 got=%b/%h exp=0010000000/c7", led, hex0); end
  endtask

  task automatic test_async_reset();
    begin_run();
    hazard_req = 1'b1;
    release_reset();
    step(7);
    checks++; if ({led, tick} !== {10'b1110000111, 1'b1}) begin errors++; $display("FAIL arst_pre got=%b/%b exp=1110000111/1", led, tick); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({led, hex0, tick, busy, mode} !== {10'b0, 8'hFF, 4'b0}) begin errors++; $display("FAIL arst_now got=%b/%h/%b/%b/%b exp=0/ff/0/0/00", led, hex0, tick, busy, mode); end
    release_reset();
    step(3);
    checks++; if ({tick, led} !== {1'b1, 10'b0}) begin errors++; $display("FAIL arst_e3 got=%b/%b exp=1/0", tick, led); end
    step(1);
    checks++; if (led !== 10'b1110000111) begin errors++; $display("FAIL arst_e4 got=%b exp=1110000111", led); end
  endtask

  initial begin
    test_reset();
    test_left();
    test_hazard();
    test_right_to_hazard();
    test_brake();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
